// File: rtl/oreg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oreg_arbiter_pkg
// Description : Shared system constants (instruction width, device index
//               width, device count) used by the sequencer, the output
//               register arbiter and the devices, plus the arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package oreg_arbiter_pkg;

    localparam int c_INST_W = 12;
    localparam int c_DEV_W  = 3;
    localparam int c_NR_DEV = 8;

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage : oreg_arbiter_pkg
`default_nettype wire

// File: rtl/oreg_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : oreg_arbiter_rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request at or above the start pointer, wrapping modulo
//               NR_REQ, as a one-hot grant and an index.
// Revision    : 1.0 - initial release
// ============================================================================
module oreg_arbiter_rr_pick #(
    parameter int NR_REQ = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NR_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]  i_start,
    output logic [NR_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx
);

    logic w_found;
    int   w_pos;

    // Walk the requesters starting at i_start and latch onto the first hit
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NR_REQ; k++) begin
            w_pos = (int'(i_start) + k) % NR_REQ;
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = IDX_W'(w_pos);
            end
        end
    end

endmodule : oreg_arbiter_rr_pick
`default_nettype wire

// File: rtl/oreg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : oreg_arbiter
// Description : Round-robin arbiter for the shared device output register.
//               A granted requester may lock the bus for a bounded burst;
//               the lock ends on an unlocked transfer, after MAX_LOCK
//               transfers, or after IDLE_TO idle cycles of the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module oreg_arbiter
    import oreg_arbiter_pkg::*;
#(
    parameter int NR_REQ   = 4,
    parameter int INST_W   = c_INST_W,
    parameter int NR_DEV   = c_NR_DEV,
    parameter int MAX_LOCK = 4,
    parameter int IDLE_TO  = 2,
    localparam int IDX_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NR_REQ-1:0]         req_valid,
    input  logic [NR_REQ*INST_W-1:0]  req_inst,
    input  logic [NR_REQ*c_DEV_W-1:0] req_dev,
    input  logic [NR_REQ-1:0]         req_lock,
    output logic [NR_REQ-1:0]         req_ready,
    output logic [INST_W-1:0]         oreg,
    output logic [NR_DEV-1:0]         oreg_wen,
    output logic [IDX_W-1:0]          owner,
    output logic                      locked
);

    localparam int c_CNT_W  = $clog2(MAX_LOCK + 1);
    localparam int c_IDLE_W = $clog2(IDLE_TO + 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_owner;
    logic [c_CNT_W-1:0]  r_lock_cnt;
    logic [c_CNT_W-1:0]  w_lock_cnt_nxt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [c_IDLE_W-1:0] w_idle_cnt_nxt;
    logic [INST_W-1:0]   r_oreg;
    logic [NR_DEV-1:0]   r_oreg_wen;

    logic [NR_REQ-1:0]   w_pick_grant;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [NR_REQ-1:0]   w_ready;
    logic [IDX_W-1:0]    w_xfer_idx;
    logic                w_xfer;
    logic [INST_W-1:0]   w_inst;
    logic [c_DEV_W-1:0]  w_dev;
    logic                w_lock;
    logic [NR_DEV-1:0]   w_wen_nxt;
    logic [IDX_W-1:0]    w_ptr_nxt;

    oreg_arbiter_rr_pick #(
        .NR_REQ (NR_REQ),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_start (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    // Grant: picker result when free, owner pinned when locked, none in reset
    always_comb begin
        w_ready    = '0;
        w_xfer_idx = r_owner;
        if (r_state == ST_LOCKED) begin
            w_ready[r_owner] = 1'b1;
        end else begin
            w_ready    = w_pick_grant;
            w_xfer_idx = w_pick_idx;
        end
        if (!reset) begin
            w_ready = '0;
        end
    end

    assign w_xfer    = |(req_valid & w_ready);
    assign w_inst    = req_inst[int'(w_xfer_idx)*INST_W +: INST_W];
    assign w_dev     = req_dev[int'(w_xfer_idx)*c_DEV_W +: c_DEV_W];
    assign w_lock    = req_lock[w_xfer_idx];
    assign w_ptr_nxt = IDX_W'((int'(w_xfer_idx) + 1) % NR_REQ);

    // Out-of-range device indices are accepted but produce no write enable
    always_comb begin
        w_wen_nxt = '0;
        if (int'(w_dev) < NR_DEV) begin
            w_wen_nxt = NR_DEV'(1) << w_dev;
        end
    end

    // Lock FSM: enter on a locked transfer, leave on unlock, burst cap or idle
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_idle_cnt_nxt = r_idle_cnt;
        case (r_state)
            ST_ARB: begin
                if (w_xfer && w_lock && (MAX_LOCK > 1)) begin
                    w_state_nxt    = ST_LOCKED;
                    w_lock_cnt_nxt = c_CNT_W'(1);
                    w_idle_cnt_nxt = '0;
                end
            end
            ST_LOCKED: begin
                if (w_xfer) begin
                    w_idle_cnt_nxt = '0;
                    if (w_lock && ((int'(r_lock_cnt) + 1) < MAX_LOCK)) begin
                        w_lock_cnt_nxt = r_lock_cnt + c_CNT_W'(1);
                    end else begin
                        w_state_nxt    = ST_ARB;
                        w_lock_cnt_nxt = '0;
                    end
                end else if ((int'(r_idle_cnt) + 1) >= IDLE_TO) begin
                    w_state_nxt    = ST_ARB;
                    w_lock_cnt_nxt = '0;
                    w_idle_cnt_nxt = '0;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + c_IDLE_W'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_ARB;
                w_lock_cnt_nxt = '0;
                w_idle_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state and burst/idle counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_ARB;
            r_lock_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
        end
    end

    // Round-robin pointer and owner follow every transfer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (w_xfer) begin
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_xfer_idx;
        end
    end

    // Output register: data holds between transfers, write enable is a pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_oreg     <= '0;
            r_oreg_wen <= '0;
        end else if (w_xfer) begin
            r_oreg     <= w_inst;
            r_oreg_wen <= w_wen_nxt;
        end else begin
            r_oreg_wen <= '0;
        end
    end

    assign req_ready = w_ready;
    assign oreg      = r_oreg;
    assign oreg_wen  = r_oreg_wen;
    assign owner     = r_owner;
    assign locked    = (r_state == ST_LOCKED);

endmodule : oreg_arbiter
`default_nettype wire

// File: tb/tb_oreg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_oreg_arbiter
// Description : Self-checking bench for oreg_arbiter: directed scenarios for
//               the documented examples followed by random traffic, checked
//               every cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oreg_arbiter;

    localparam int NR_REQ   = 4;
    localparam int INST_W   = 12;
    localparam int NR_DEV   = 6;
    localparam int MAX_LOCK = 4;
    localparam int IDLE_TO  = 2;

    logic                     clock = 1'b0;
    logic                     reset = 1'b0;
    logic [NR_REQ-1:0]        req_valid;
    logic [NR_REQ*INST_W-1:0] req_inst;
    logic [NR_REQ*3-1:0]      req_dev;
    logic [NR_REQ-1:0]        req_lock;
    logic [NR_REQ-1:0]        req_ready;
    logic [INST_W-1:0]        oreg;
    logic [NR_DEV-1:0]        oreg_wen;
    logic [1:0]               owner;
    logic                     locked;

    oreg_arbiter #(
        .NR_REQ   (NR_REQ),
        .INST_W   (INST_W),
        .NR_DEV   (NR_DEV),
        .MAX_LOCK (MAX_LOCK),
        .IDLE_TO  (IDLE_TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_inst  (req_inst),
        .req_dev   (req_dev),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .oreg      (oreg),
        .oreg_wen  (oreg_wen),
        .owner     (owner),
        .locked    (locked)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who holds the bus, how long the burst is, idle time
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_burst;
    int m_idle;
    int m_oreg;
    int m_wen;
    int e_ready;

    logic [NR_REQ-1:0] seen_ready;
    logic              seen_locked;
    logic [INST_W-1:0] seen_oreg;
    logic [NR_DEV-1:0] seen_wen;

    int r31_exp [5] = '{4, 4, 4, 1, 4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_burst  = 0;
        m_idle   = 0;
        m_oreg   = 0;
        m_wen    = 0;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_inst  = '0;
        req_dev   = '0;
        req_lock  = '0;
    endtask

    task automatic set_req(input int i, input bit v, input int inst, input int dev, input bit lk);
        req_valid[i]             = v;
        req_inst[i*INST_W +: INST_W] = inst[INST_W-1:0];
        req_dev[i*3 +: 3]        = dev[2:0];
        req_lock[i]              = lk;
    endtask

    // One clock: check all outputs mid-cycle, then advance the model
    task automatic cycle();
        int w;
        @(negedge clock);
        e_ready = 0;
        if (reset) begin
            if (m_locked) begin
                e_ready = 1 << m_owner;
            end else begin
                for (int k = 0; k < NR_REQ; k++) begin
                    if (e_ready == 0 && req_valid[(m_ptr + k) % NR_REQ]) begin
                        e_ready = 1 << ((m_ptr + k) % NR_REQ);
                    end
                end
            end
        end
        seen_ready  = req_ready;
        seen_locked = locked;
        seen_oreg   = oreg;
        seen_wen    = oreg_wen;
        chk("ready", req_ready, e_ready);
        chk("oreg", oreg, m_oreg);
        chk("oreg_wen", oreg_wen, m_wen);
        chk("owner", owner, m_owner);
        chk("locked", locked, m_locked);
        w = -1;
        for (int j = 0; j < NR_REQ; j++) begin
            if (req_valid[j] && e_ready[j]) w = j;
        end
        if (reset) begin
            if (w >= 0) begin
                int dev;
                dev     = int'(req_dev[w*3 +: 3]);
                m_oreg  = int'(req_inst[w*INST_W +: INST_W]);
                m_wen   = (dev < NR_DEV) ? (1 << dev) : 0;
                m_ptr   = (w + 1) % NR_REQ;
                m_owner = w;
                if (!m_locked) begin
                    if (req_lock[w] && MAX_LOCK > 1) begin
                        m_locked = 1'b1;
                        m_burst  = 1;
                        m_idle   = 0;
                    end
                end else begin
                    m_idle = 0;
                    if (req_lock[w] && (m_burst + 1) < MAX_LOCK) m_burst++;
                    else m_locked = 1'b0;
                end
            end else begin
                m_wen = 0;
                if (m_locked) begin
                    m_idle++;
                    if (m_idle >= IDLE_TO) m_locked = 1'b0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        clear_req();
        model_reset();
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;

        // Single request, device 3
        set_req(0, 1'b1, 'hA5C, 3, 1'b0);
        cycle();
        chk("r29_ready_t", seen_ready, 4'b0001);
        clear_req();
        cycle();
        chk("r29_oreg_t1", seen_oreg, 12'hA5C);
        chk("r29_wen_t1", seen_wen, 6'h08);
        cycle();
        chk("r29_wen_t2", seen_wen, 6'h00);

        // Four requesters, no lock: plain rotation
        do_reset();
        for (int i = 0; i < NR_REQ; i++) set_req(i, 1'b1, 'h100 + i, i, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk($sformatf("r30_grant%0d", i), seen_ready, 1 << (i % NR_REQ));
        end

        // Requester 2 locks while requester 0 waits
        do_reset();
        clear_req();
        set_req(2, 1'b1, 'h200, 1, 1'b1);
        cycle();
        chk("r31_first", seen_ready, 4'b0100);
        set_req(0, 1'b1, 'h100, 2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_req(2, 1'b1, 'h201 + i, 1, 1'b1);
            cycle();
            chk($sformatf("r31_grant%0d", i), seen_ready, r31_exp[i]);
        end

        // Owner goes idle; lock times out and the waiter gets the bus
        do_reset();
        clear_req();
        set_req(1, 1'b1, 'h111, 4, 1'b1);
        cycle();
        clear_req();
        set_req(3, 1'b1, 'h333, 5, 1'b0);
        cycle();
        chk("r32_idle1_locked", seen_locked, 1'b1);
        chk("r32_idle1_ready", seen_ready, 4'b0010);
        cycle();
        chk("r32_idle2_locked", seen_locked, 1'b1);
        cycle();
        chk("r32_after_locked", seen_locked, 1'b0);
        chk("r32_after_ready", seen_ready, 4'b1000);

        // Device index beyond the device count
        do_reset();
        clear_req();
        set_req(0, 1'b1, 'h123, 7, 1'b0);
        cycle();
        set_req(0, 1'b1, 'h000, 0, 1'b0);
        set_req(1, 1'b1, 'h456, 0, 1'b0);
        cycle();
        chk("r33_oreg", seen_oreg, 12'h123);
        chk("r33_wen", seen_wen, 6'h00);
        chk("r33_ptr_adv", seen_ready, 4'b0010);

        // Asynchronous reset in the middle of a locked burst
        do_reset();
        clear_req();
        set_req(0, 1'b1, 'h0AA, 1, 1'b1);
        cycle();
        set_req(0, 1'b1, 'h0AB, 2, 1'b1);
        cycle();
        #2;
        reset = 1'b0;
        #1;
        chk("r34_async_ready", req_ready, 4'b0000);
        chk("r34_async_oreg", oreg, 12'h000);
        chk("r34_async_wen", oreg_wen, 6'h00);
        chk("r34_async_owner", owner, 2'd0);
        chk("r34_async_locked", locked, 1'b0);
        model_reset();
        cycle();
        cycle();
        reset = 1'b1;
        clear_req();
        set_req(1, 1'b1, 'h001, 1, 1'b0);
        set_req(3, 1'b1, 'h003, 3, 1'b0);
        cycle();
        chk("r34_first_grant", seen_ready, 4'b0010);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR_REQ; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                        int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_oreg_arbiter
`default_nettype wire
